// File: rtl/host_cmd_initiator_if.sv
// Handshake bundle between the host controller, the initiator and the uart_tx/uart_rx pair.
// master: the initiator's view; slave: the host/UART environment's view.
interface host_cmd_initiator_if;
    logic        Start_in;
    logic [7:0]  Ins_in;
    logic [15:0] A_in;
    logic [15:0] B_in;
    logic        Tx_DV_out;
    logic [7:0]  Tx_Byte_out;
    logic        Tx_Done_in;
    logic        Rx_DV_in;
    logic [7:0]  Rx_Byte_in;
    logic        Busy_out;
    logic [15:0] Result_out;
    logic        Result_valid_out;
    logic        Timeout_out;

    modport master (
        input  Start_in, Ins_in, A_in, B_in,
        input  Tx_Done_in, Rx_DV_in, Rx_Byte_in,
        output Tx_DV_out, Tx_Byte_out, Busy_out,
        output Result_out, Result_valid_out, Timeout_out
    );

    modport slave (
        output Start_in, Ins_in, A_in, B_in,
        output Tx_Done_in, Rx_DV_in, Rx_Byte_in,
        input  Tx_DV_out, Tx_Byte_out, Busy_out,
        input  Result_out, Result_valid_out, Timeout_out
    );
endinterface

// File: rtl/host_cmd_initiator.sv
// Host-side initiator: sends a 5-byte command frame over UART TX,
// then collects the 2-byte MSB-first response from UART RX.
module host_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input logic                  CLK,
    input logic                  RST,
    host_cmd_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RECV
    } state_e;

    // Counter value seen on the cycle that would push it to TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    state_e          state_q, state_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic            rx_cnt_q, rx_cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      ins_q, ins_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [7:0]      msb_q, msb_d;
    logic [15:0]     res_q, res_d;
    logic            rv_q, rv_d;
    logic            tmo_q, tmo_d;
    logic [7:0]      tx_byte;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            tx_idx_q <= 3'd0;
            rx_cnt_q <= 1'b0;
            to_q     <= '0;
            ins_q    <= 8'h00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            msb_q    <= 8'h00;
            res_q    <= 16'h0000;
            rv_q     <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_idx_q <= tx_idx_d;
            rx_cnt_q <= rx_cnt_d;
            to_q     <= to_d;
            ins_q    <= ins_d;
            a_q      <= a_d;
            b_q      <= b_d;
            msb_q    <= msb_d;
            res_q    <= res_d;
            rv_q     <= rv_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_idx_d = tx_idx_q;
        rx_cnt_d = rx_cnt_q;
        to_d     = to_q;
        ins_d    = ins_q;
        a_d      = a_q;
        b_d      = b_q;
        msb_d    = msb_q;
        res_d    = res_q;
        rv_d     = 1'b0;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start_in) begin
                    ins_d    = bus.Ins_in;
                    a_d      = bus.A_in;
                    b_d      = bus.B_in;
                    tx_idx_d = 3'd0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.Tx_Done_in) begin
                    if (tx_idx_q == 3'd4) begin
                        rx_cnt_d = 1'b0;
                        to_d     = '0;
                        state_d  = RECV;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        state_d  = SEND;
                    end
                end
            end
            RECV: begin
                // A byte arriving on the limit cycle takes priority over the timeout.
                if (bus.Rx_DV_in) begin
                    if (!rx_cnt_q) begin
                        msb_d    = bus.Rx_Byte_in;
                        rx_cnt_d = 1'b1;
                        to_d     = '0;
                    end else begin
                        res_d   = {msb_q, bus.Rx_Byte_in};
                        rv_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        if (state_q == SEND || state_q == WAIT_TX) begin
            case (tx_idx_q)
                3'd0:    tx_byte = ins_q;
                3'd1:    tx_byte = a_q[15:8];
                3'd2:    tx_byte = a_q[7:0];
                3'd3:    tx_byte = b_q[15:8];
                3'd4:    tx_byte = b_q[7:0];
                default: tx_byte = 8'h00;
            endcase
        end
    end

    assign bus.Tx_DV_out        = (state_q == SEND);
    assign bus.Tx_Byte_out      = tx_byte;
    assign bus.Busy_out         = (state_q != IDLE);
    assign bus.Result_out       = res_q;
    assign bus.Result_valid_out = rv_q;
    assign bus.Timeout_out      = tmo_q;

endmodule
